// File: rtl/store_buffer.sv
// Store buffer: posted-write FIFO between the data cache write path and memory.
// Accepts word/byte stores in one cycle, drains them in order over a
// valid/ready handshake, forwards pending word stores to the load path and
// flags a stall when the youngest matching pending store is a byte store.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   st_valid/st_ready           store handshake; st_addr, st_data, st_byte payload
//   ld_addr                     load address probed for forwarding
//   fwd_hit/fwd_data/fwd_stall  combinational forwarding result
//   mem_valid/mem_ready         drain handshake; mem_addr, mem_data, mem_byte head entry
//   empty, full, count          occupancy
//   total_stores                stores accepted
//   total_stall_cycles          cycles with st_valid && !st_ready
module store_buffer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [ADDR_WIDTH-1:0]   st_addr,
  input  logic [DATA_WIDTH-1:0]   st_data,
  input  logic                    st_byte,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  output logic                    fwd_hit,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  output logic                    fwd_stall,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data,
  output logic                    mem_byte,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic [31:0]             total_stores,
  output logic [31:0]             total_stall_cycles
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Entry storage; payload is only meaningful where the valid bit is set.
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic                  byte_q [DEPTH];
  logic [DEPTH-1:0]      vld_q, vld_d;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   stores_q, stores_d;
  logic [31:0]   stalls_q, stalls_d;

  logic full_c, empty_c, push_c, pop_c;

  // Word-granular forwarding ignores the byte offset bits of the load address.
  logic unused_ld_bits;
  assign unused_ld_bits = ^ld_addr[1:0];

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);
  // No same-cycle refill: a full buffer refuses even if the head pops.
  assign push_c  = st_valid && !full_c;
  assign pop_c   = !empty_c && mem_ready;

  // Next-state for pointers, occupancy, valid bits and counters.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    count_d  = count_q + CW'(push_c) - CW'(pop_c);
    stores_d = stores_q + 32'(push_c);
    stalls_d = stalls_q + 32'(st_valid && full_c);
    if (push_c) begin
      wr_ptr_d         = wr_ptr_q + PW'(1);
      vld_d[wr_ptr_q]  = 1'b1;
    end
    if (pop_c) begin
      rd_ptr_d         = rd_ptr_q + PW'(1);
      vld_d[rd_ptr_q]  = 1'b0;
    end
  end

  // Control state with asynchronous reset; discards all pending stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      stores_q <= '0;
      stalls_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      stores_q <= stores_d;
      stalls_q <= stalls_d;
    end
  end

  // Payload write; no reset needed since valid bits gate every use.
  always_ff @(posedge clk) begin
    if (push_c) begin
      addr_q[wr_ptr_q] <= st_addr;
      data_q[wr_ptr_q] <= st_data;
      byte_q[wr_ptr_q] <= st_byte;
    end
  end

  // Forwarding: walk oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr_q - PW'(k);
      if (vld_q[idx] && (addr_q[idx][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2])) begin
        fwd_hit   = !byte_q[idx];
        fwd_stall = byte_q[idx];
        fwd_data  = byte_q[idx] ? '0 : data_q[idx];
      end
    end
  end

  assign st_ready           = !full_c;
  assign full               = full_c;
  assign empty              = empty_c;
  assign count              = count_q;
  assign mem_valid          = !empty_c;
  assign mem_addr           = addr_q[rd_ptr_q];
  assign mem_data           = data_q[rd_ptr_q];
  assign mem_byte           = byte_q[rd_ptr_q];
  assign total_stores       = stores_q;
  assign total_stall_cycles = stalls_q;

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the data cache write path and data memory.
- Accepts word and byte stores in one cycle and drains them to memory in order over a valid/ready handshake.
- Lets the cache's load path forward pending word stores, and flags a stall when a pending byte store prevents forwarding.
- Exposes occupancy and performance counters in the same style as the cache counters.

Parameters:
ADDR_WIDTH, 32, store/load address width
DATA_WIDTH, 32, store data width
DEPTH, 4, entries; power of two, minimum 2

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
st_valid  in  1  store request from cache write path
st_ready  out  1  buffer can accept a store (= !full)
st_addr  in  ADDR_WIDTH  store byte address
st_data  in  DATA_WIDTH  store data; byte stores use [7:0]
st_byte  in  1  1 = byte store (AddrMode 3'b001/3'b010), 0 = word
ld_addr  in  ADDR_WIDTH  load address probed for forwarding
fwd_hit  out  1  youngest matching entry is a word store
fwd_data  out  DATA_WIDTH  data of that entry; 0 when !fwd_hit
fwd_stall  out  1  youngest matching entry is a byte store
mem_valid  out  1  head entry presented to memory
mem_ready  in  1  memory accepts head this cycle
mem_addr  out  ADDR_WIDTH  head address
mem_data  out  DATA_WIDTH  head data
mem_byte  out  1  head store type
empty  out  1  count == 0
full  out  1  count == DEPTH
count  out  $clog2(DEPTH)+1  current occupancy
total_stores  out  32  stores accepted
total_stall_cycles  out  32  cycles with st_valid && !st_ready

Behaviour:
- Reset (async, rst=1): wr_ptr, rd_ptr and count cleared; all entry valid bits cleared; counters cleared. Resulting outputs: empty=1, full=0, st_ready=1, mem_valid=0, fwd_hit=0, fwd_stall=0, fwd_data=0. mem_addr/mem_data/mem_byte are don't-care while mem_valid=0.
- Reset mid-operation discards all pending stores; nothing further is presented to memory.
- Push: st_valid && st_ready at an edge writes {addr, data, byte} at wr_ptr. wr_ptr increments modulo DEPTH (natural wrap).
- Pop: mem_valid && mem_ready at an edge retires the entry at rd_ptr. rd_ptr increments modulo DEPTH.
- Simultaneous push and pop: both occur and count is unchanged. When full, st_ready=0 even if a pop occurs in the same cycle (no same-cycle refill).
- Empty buffer: no bypass. A store pushed at edge N is presented on mem_valid from cycle N+1 (latency 1 cycle).
- mem_valid = !empty. mem_addr, mem_data and mem_byte come straight from the head entry and stay stable while mem_valid && !mem_ready.
- Stores drain in strict FIFO order.
- Forwarding is purely combinational on ld_addr:
  - Compare ld_addr[ADDR_WIDTH-1:2] against every valid entry's address[ADDR_WIDTH-1:2].
  - Select the youngest match (closest to wr_ptr-1, wrap-aware).
  - Youngest match is a word store: fwd_hit=1, fwd_data = its data.
  - Youngest match is a byte store: fwd_stall=1, fwd_hit=0.
  - No match: both 0.
  - An entry popping this cycle still participates; an entry being pushed this cycle does not.
- Counters:
  - total_stores increments on each push.
  - total_stall_cycles increments each cycle with st_valid && !st_ready.
  - Both are 32-bit and wrap silently at 2^32.
- st_valid while full: no state change apart from the stall counter. The requester must hold the request.

Test Plan:
- Reset then single word store: addr 0x10, data 0xDEADBEEF, mem_ready=1 → mem_valid rises the next cycle with mem_addr=0x10, mem_data=0xDEADBEEF; empty=1 after the pop; total_stores=1.
- Fill with mem_ready=0: push 4 stores → full=1, st_ready=0, count=4. Hold st_valid 3 more cycles → total_stall_cycles=3. Raise mem_ready → drains in push order.
- Forwarding: word stores to 0x20 (data 0x11111111) then 0x20 (data 0x22222222), ld_addr=0x23 → fwd_hit=1, fwd_data=0x22222222. Then byte store to 0x21 → fwd_stall=1, fwd_hit=0.
- Steady push+pop with count=2 over 10 cycles: count stays 2, pointers wrap past DEPTH, and memory receives all stores in order with no loss or duplication.
- Assert rst mid-drain with count=3 → outputs return to reset values asynchronously; no further mem_valid; counters read 0.
- Byte store: addr 0x43, data 0x000000AB → mem_byte=1, mem_addr=0x43, mem_data[7:0]=0xAB.
